multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle control decoder for the 32-bit processor. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with instruction and data memory that may insert wait states. It drives the same datapath control set, plus PC, IR and stack-pointer write strobes, and keeps a retired-instruction counter. It sits between the instruction register and the datapath and replaces the purely combinational decode path.

## Interface
Parameters:
- OPCODE_W, 5: opcode width, ≥5. Any nonzero bit above bit 4 marks the instruction illegal.
- FUNCT_W, 4: funct width, ≥4. Any nonzero bit above bit 3 marks the instruction illegal.
- WAIT_MAX, 15: maximum wait cycles per memory access before bus error.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock. All state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  IR opcode field. Sampled in DECODE.
- funct  in  FUNCT_W  IR funct field. Sampled in DECODE.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- ifetch_req  out  1  instruction fetch request.
- ir_write  out  1  IR load strobe.
- reg_d, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch  out  1 each  datapath controls.
- alu_op  out  4  ALU operation code.
- stack_push, stack_pop, sp_write, pc_write  out  1 each  stack and PC controls.
- state  out  3  current state, for debug.
- retired  out  CNT_W  count of completed instructions.
- bus_error  out  1  sticky memory timeout flag.
- illegal  out  1  illegal instruction flag.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: ifetch_req=1. When imem_ready=1, pulse ir_write and go to DECODE.
- DECODE: latch opcode/funct into internal op registers. Go to EXEC, or take the illegal path below.
- Decode table (latched op, independent of state). Unlisted controls are 0:
  - Opcode 0, R-type: reg_d=1, reg_write=1. funct 0..8 give alu_op 0000,1010,0001,1001,0010,0011,0100,0110,0101. Funct 9..15 are illegal.
  - Opcodes 1..9, I-type: alu_src=1, reg_write=1. alu_op is 0000,1010,0001,1001,0010,1011,0100,0110,0101 respectively.
  - Opcodes 10/12, load: alu_src=1, mem_read, mem_to_reg, reg_write.
  - Opcodes 11/13, store: alu_src=1, mem_write.
  - Opcodes 14..17, branch: branch=1, alu_op=0111.
  - Opcode 18, push: stack_push. Opcode 19, pop: stack_pop, mem_to_reg, reg_write.
  - Opcode 22, move: alu_src=1, reg_write=1, alu_op=0000.
  - Opcodes 20, 21, 23..31 are illegal.
- Per-state qualification of the decoded values:
  - EXEC: alu_op, alu_src and branch are valid. All strobes are 0.
  - MEM: only loads, stores, push and pop enter MEM. mem_read (load/pop) or mem_write (store/push) is held until dmem_ready=1, then go to WB.
  - WB: pc_write=1. reg_write is gated on in WB only. sp_write=1 for push and pop. retired increments and wraps modulo 2^CNT_W. Then go to FETCH.
- All other instructions go EXEC→WB directly.
- Wait counter: resets on entry to FETCH or MEM and increments each cycle ready=0. If ready is still 0 after WAIT_MAX waits, set bus_error and go to HALT.
- Simultaneous: ready arriving on the same cycle the count reaches WAIT_MAX counts as success.
- HALT: all strobes are 0. Only reset exits HALT.
- Reset: in any state, the next state is FETCH. All outputs are 0 (state=0, retired=0, bus_error=0, illegal=0). Any pending memory request drops on the cycle after reset is sampled.

## Timing
- All outputs are decoded from registered state and latched op. There is no input-to-output combinational path except ir_write (imem_ready & FETCH).
- Zero-wait latency: ALU, branch and move take 4 cycles. Loads, stores, push and pop take 5 cycles. Each wait cycle adds 1.
- mem_read/mem_write stay stable while in MEM. The datapath must keep the address stable while the request is high.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal op in DECODE sets illegal=1 (sticky until reset) and goes to HALT. No strobes fire and retired does not increment.
- CTRL_ILLEGAL_TRAP_EN undefined: an illegal op executes as a NOP through DECODE→EXEC→WB. pc_write=1, all other strobes 0, retired increments, and illegal stays 0.

## Test plan
- Reset, then opcode=0/funct=2 with ready tied high → alu_op=0001 in EXEC, reg_write=1 only in WB cycle 4, retired=1.
- Load (opcode 10) with dmem_ready delayed 3 cycles → mem_read high for 4 cycles, WB at cycle 8, mem_to_reg=1, reg_write=1.
- Push (18) then pop (19) → stack_push in MEM then sp_write in WB; stack_pop, reg_write and sp_write in the second WB; retired=2.
- imem_ready held 0 with WAIT_MAX=15 → bus_error=1 after 16 FETCH cycles, state=5, no ir_write; reset returns to state=0 with bus_error=0.
- Opcode 21 → with macro: illegal=1, state=5, retired unchanged; without macro: pc_write pulse, retired+1, illegal=0.
- Reset asserted during MEM of a store → mem_write low on the next cycle, state=0, retired=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait-state timeout and retire counter.
// Build option CTRL_ILLEGAL_TRAP_EN: illegal ops halt the core; otherwise they retire as NOPs.
module multicycle_control_unit #(
  parameter int OPCODE_W = 5,
  parameter int FUNCT_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                ifetch_req,
  output logic                ir_write,
  output logic                reg_d,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic [3:0]          alu_op,
  output logic                stack_push,
  output logic                stack_pop,
  output logic                sp_write,
  output logic                pc_write,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired,
  output logic                bus_error,
  output logic                illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic       ill;
    logic       reg_d;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       stack_push;
    logic       stack_pop;
    logic [3:0] alu_op;
  } dec_t;

  // An illegal op decodes to all-zero controls, which is exactly the NOP behaviour.
  function automatic dec_t decode_op(input logic [4:0] op, input logic [3:0] fn,
                                     input logic hi_bad);
    dec_t d;
    d = '0;
    case (op) inside
      5'd0: begin
        d.reg_d     = 1'b1;
        d.reg_write = 1'b1;
        case (fn)
          4'd0:    d.alu_op = 4'b0000;
          4'd1:    d.alu_op = 4'b1010;
          4'd2:    d.alu_op = 4'b0001;
          4'd3:    d.alu_op = 4'b1001;
          4'd4:    d.alu_op = 4'b0010;
          4'd5:    d.alu_op = 4'b0011;
          4'd6:    d.alu_op = 4'b0100;
          4'd7:    d.alu_op = 4'b0110;
          4'd8:    d.alu_op = 4'b0101;
          default: d.ill    = 1'b1;
        endcase
      end
      [5'd1:5'd9]: begin
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
        case (op)
          5'd1:    d.alu_op = 4'b0000;
          5'd2:    d.alu_op = 4'b1010;
          5'd3:    d.alu_op = 4'b0001;
          5'd4:    d.alu_op = 4'b1001;
          5'd5:    d.alu_op = 4'b0010;
          5'd6:    d.alu_op = 4'b1011;
          5'd7:    d.alu_op = 4'b0100;
          5'd8:    d.alu_op = 4'b0110;
          5'd9:    d.alu_op = 4'b0101;
          default: d.alu_op = 4'b0000;
        endcase
      end
      5'd10, 5'd12: begin
        d.alu_src    = 1'b1;
        d.mem_read   = 1'b1;
        d.mem_to_reg = 1'b1;
        d.reg_write  = 1'b1;
      end
      5'd11, 5'd13: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
      end
      [5'd14:5'd17]: begin
        d.branch = 1'b1;
        d.alu_op = 4'b0111;
      end
      5'd18: d.stack_push = 1'b1;
      5'd19: begin
        d.stack_pop  = 1'b1;
        d.mem_to_reg = 1'b1;
        d.reg_write  = 1'b1;
      end
      5'd22: begin
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
      end
      default: d.ill = 1'b1;
    endcase
    if (hi_bad || d.ill) begin
      d     = '0;
      d.ill = 1'b1;
    end
    return d;
  endfunction

  function automatic logic is_illegal(input logic [4:0] op, input logic [3:0] fn,
                                      input logic hi_bad);
    dec_t d;
    d = decode_op(op, fn, hi_bad);
    return d.ill;
  endfunction

  state_t         state_q, state_n;
  logic [4:0]     op_q;
  logic [3:0]     fn_q;
  logic           hi_q;
  logic [WCW-1:0] wait_cnt;
  logic           set_bus_error, set_illegal;
  logic           raw_hi_bad, raw_illegal, mem_class;
  dec_t           dec_q;

  // Extra opcode/funct bits beyond the base encoding make any instruction illegal.
  assign raw_hi_bad  = ((opcode >> 5) != '0) || ((funct >> 4) != '0);
  assign raw_illegal = is_illegal(opcode[4:0], funct[3:0], raw_hi_bad);
  assign dec_q       = decode_op(op_q, fn_q, hi_q);
  assign mem_class   = ~dec_q.ill & (dec_q.mem_read | dec_q.mem_write |
                                     dec_q.stack_push | dec_q.stack_pop);
  assign state       = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      hi_q      <= 1'b0;
      wait_cnt  <= '0;
      retired   <= '0;
      bus_error <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q <= state_n;
      // Counter restarts on every state change, so it is zero on FETCH and MEM entry.
      if (state_n != state_q)
        wait_cnt <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
        wait_cnt <= wait_cnt + 1'b1;
      if (state_q == S_DECODE) begin
        op_q <= opcode[4:0];
        fn_q <= funct[3:0];
        hi_q <= raw_hi_bad;
      end
      if (set_bus_error) bus_error <= 1'b1;
      if (set_illegal)   illegal   <= 1'b1;
      if (state_q == S_WB) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_n       = state_q;
    set_bus_error = 1'b0;
    set_illegal   = 1'b0;
    ifetch_req    = 1'b0;
    ir_write      = 1'b0;
    reg_d         = 1'b0;
    alu_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    branch        = 1'b0;
    alu_op        = 4'b0000;
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
    sp_write      = 1'b0;
    pc_write      = 1'b0;
    // Datapath steering levels are driven from EXEC through WB; strobes only in their own state.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      reg_d      = dec_q.reg_d;
      alu_src    = dec_q.alu_src;
      mem_to_reg = dec_q.mem_to_reg;
      branch     = dec_q.branch;
      alu_op     = dec_q.alu_op;
    end
    if (state_q == S_MEM || state_q == S_WB) begin
      stack_push = dec_q.stack_push;
      stack_pop  = dec_q.stack_pop;
    end
    case (state_q)
      S_FETCH: begin
        ifetch_req = 1'b1;
        ir_write   = imem_ready;
        if (imem_ready) begin
          state_n = S_DECODE;
        end else if (wait_cnt == WAIT_LIM) begin
          set_bus_error = 1'b1;
          state_n       = S_HALT;
        end
      end
      S_DECODE: begin
        if (TRAP_EN && raw_illegal) begin
          set_illegal = 1'b1;
          state_n     = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: state_n = mem_class ? S_MEM : S_WB;
      S_MEM: begin
        mem_read  = dec_q.mem_read | dec_q.stack_pop;
        mem_write = dec_q.mem_write | dec_q.stack_push;
        if (dmem_ready) begin
          state_n = S_WB;
        end else if (wait_cnt == WAIT_LIM) begin
          set_bus_error = 1'b1;
          state_n       = S_HALT;
        end
      end
      S_WB: begin
        reg_write = dec_q.reg_write;
        sp_write  = dec_q.stack_push | dec_q.stack_pop;
        pc_write  = 1'b1;
        state_n   = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: scripted per-cycle stimulus with expectations from an instruction-level model.
module tb_multicycle_control_unit;
  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 4;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 32;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                imem_ready, dmem_ready;
  logic                ifetch_req, ir_write, reg_d, alu_src, mem_read, mem_write;
  logic                mem_to_reg, reg_write, branch;
  logic [3:0]          alu_op;
  logic                stack_push, stack_pop, sp_write, pc_write;
  logic [2:0]          state;
  logic [CNT_W-1:0]    retired;
  logic                bus_error, illegal;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ifetch_req(ifetch_req), .ir_write(ir_write), .reg_d(reg_d), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .branch(branch), .alu_op(alu_op),
    .stack_push(stack_push), .stack_pop(stack_pop), .sp_write(sp_write),
    .pc_write(pc_write), .state(state), .retired(retired),
    .bus_error(bus_error), .illegal(illegal)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic ifetch_req, ir_write, reg_d, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch;
    logic [3:0] alu_op;
    logic stack_push, stack_pop, sp_write, pc_write;
    logic [2:0] state;
    logic bus_error, illegal;
    logic [CNT_W-1:0] retired;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  typedef struct packed {
    logic rst, imem, dmem;
    logic [OPCODE_W-1:0] op;
    logic [FUNCT_W-1:0]  fn;
  } stim_t;

  typedef enum {K_RTYPE, K_ITYPE, K_LOAD, K_STORE, K_BRANCH, K_PUSH, K_POP, K_MOVE, K_NOP} kind_t;

  logic [OBS_W-1:0] exp_q[$];
  stim_t            stim_q[$];
  int               checks = 0, errors = 0;
  int               m_retired;
  bit               m_bus, m_ill, m_halted;
  int               n_cycles, n_mem_read, n_reg_write, n_sp_write, n_ir_write;
  logic [3:0]       last_exec_alu;

  logic [3:0] rt_alu [0:8] = '{4'b0000, 4'b1010, 4'b0001, 4'b1001, 4'b0010,
                               4'b0011, 4'b0100, 4'b0110, 4'b0101};
  logic [3:0] it_alu [1:9] = '{4'b0000, 4'b1010, 4'b0001, 4'b1001, 4'b0010,
                               4'b1011, 4'b0100, 4'b0110, 4'b0101};

  function automatic kind_t classify(input logic [OPCODE_W-1:0] op, input logic [FUNCT_W-1:0] fn);
    int o;
    o = int'(op);
    if (o > 31) return K_NOP;
    if (o == 0) return (int'(fn) <= 8) ? K_RTYPE : K_NOP;
    if (o <= 9) return K_ITYPE;
    if (o == 10 || o == 12) return K_LOAD;
    if (o == 11 || o == 13) return K_STORE;
    if (o >= 14 && o <= 17) return K_BRANCH;
    if (o == 18) return K_PUSH;
    if (o == 19) return K_POP;
    if (o == 22) return K_MOVE;
    return K_NOP;
  endfunction

  function automatic obs_t base(input int st);
    obs_t o;
    o           = '0;
    o.state     = 3'(st);
    o.retired   = CNT_W'(m_retired);
    o.bus_error = m_bus;
    o.illegal   = m_ill;
    return o;
  endfunction

  function automatic obs_t levels(input kind_t k, input logic [OPCODE_W-1:0] op,
                                  input logic [FUNCT_W-1:0] fn, input int st);
    obs_t o;
    o            = base(st);
    o.reg_d      = (k == K_RTYPE);
    o.alu_src    = k inside {K_ITYPE, K_LOAD, K_STORE, K_MOVE};
    o.mem_to_reg = k inside {K_LOAD, K_POP};
    o.branch     = (k == K_BRANCH);
    if (k == K_RTYPE) o.alu_op = rt_alu[int'(fn)];
    else if (k == K_ITYPE) o.alu_op = it_alu[int'(op)];
    else if (k == K_BRANCH) o.alu_op = 4'b0111;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_cyc(input bit rst, input bit im, input bit dm,
                          input logic [OPCODE_W-1:0] op, input logic [FUNCT_W-1:0] fn, input obs_t o);
    stim_t s;
    s.rst = rst; s.imem = im; s.dmem = dm; s.op = op; s.fn = fn;
    stim_q.push_back(s);
    exp_q.push_back(o);
  endtask

  function automatic logic [OPCODE_W-1:0] rnd_op();
    return OPCODE_W'($urandom);
  endfunction

  function automatic logic [FUNCT_W-1:0] rnd_fn();
    return FUNCT_W'($urandom);
  endfunction

  task automatic model_reset();
    m_retired = 0; m_bus = 1'b0; m_ill = 1'b0; m_halted = 1'b0;
  endtask

  task automatic add_halt();
    repeat (3) push_cyc(1'b0, 1'($urandom), 1'($urandom), rnd_op(), rnd_fn(), base(5));
    m_halted = 1'b1;
  endtask

  task automatic add_reset();
    push_cyc(1'b1, 1'b0, 1'b0, rnd_op(), rnd_fn(), base(5));
    model_reset();
  endtask

  // One instruction: fetch waits fw, data waits dw; waits beyond WAIT_MAX time out.
  task automatic gen_instr(input logic [OPCODE_W-1:0] op, input logic [FUNCT_W-1:0] fn,
                           input int fw, input int dw, input bit rst_mem);
    kind_t k;
    bit    is_mem, rdy;
    obs_t  o;
    k      = classify(op, fn);
    is_mem = k inside {K_LOAD, K_STORE, K_PUSH, K_POP};
    for (int i = 0; i <= WAIT_MAX; i++) begin
      rdy = (i == fw);
      o = base(0); o.ifetch_req = 1'b1; o.ir_write = rdy;
      push_cyc(1'b0, rdy, 1'($urandom), rnd_op(), rnd_fn(), o);
      if (rdy) break;
    end
    if (fw > WAIT_MAX) begin m_bus = 1'b1; add_halt(); return; end
    push_cyc(1'b0, 1'($urandom), 1'($urandom), op, fn, base(1));
    if (k == K_NOP && TRAP_EN) begin m_ill = 1'b1; add_halt(); return; end
    push_cyc(1'b0, 1'($urandom), 1'($urandom), rnd_op(), rnd_fn(), levels(k, op, fn, 2));
    if (is_mem) begin
      for (int i = 0; i <= WAIT_MAX; i++) begin
        rdy = (i == dw);
        o = levels(k, op, fn, 3);
        o.mem_read   = k inside {K_LOAD, K_POP};
        o.mem_write  = k inside {K_STORE, K_PUSH};
        o.stack_push = (k == K_PUSH);
        o.stack_pop  = (k == K_POP);
        push_cyc(rst_mem, 1'($urandom), rdy, rnd_op(), rnd_fn(), o);
        if (rst_mem) begin model_reset(); return; end
        if (rdy) break;
      end
      if (dw > WAIT_MAX) begin m_bus = 1'b1; add_halt(); return; end
    end
    o = levels(k, op, fn, 4);
    o.stack_push = (k == K_PUSH);
    o.stack_pop  = (k == K_POP);
    o.reg_write  = k inside {K_RTYPE, K_ITYPE, K_LOAD, K_POP, K_MOVE};
    o.sp_write   = k inside {K_PUSH, K_POP};
    o.pc_write   = 1'b1;
    push_cyc(1'b0, 1'($urandom), 1'($urandom), rnd_op(), rnd_fn(), o);
    m_retired++;
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 39);
    if (r < 30) return r % 3;
    if (r < 37) return $urandom_range(3, WAIT_MAX);
    if (r < 39) return WAIT_MAX;
    return WAIT_MAX + 1;
  endfunction

  // ---------------- scoreboard / compare ----------------
  task automatic run_stream();
    stim_t s;
    obs_t  e, got;
    n_cycles = 0; n_mem_read = 0; n_reg_write = 0; n_sp_write = 0; n_ir_write = 0;
    last_exec_alu = 4'hx;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; imem_ready = s.imem; dmem_ready = s.dmem; opcode = s.op; funct = s.fn;
      #1;
      got = '{ifetch_req, ir_write, reg_d, alu_src, mem_read, mem_write, mem_to_reg, reg_write,
              branch, alu_op, stack_push, stack_pop, sp_write, pc_write, state,
              bus_error, illegal, retired};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, got, e);
      end
      n_cycles++;
      if (mem_read)  n_mem_read++;
      if (reg_write) n_reg_write++;
      if (sp_write)  n_sp_write++;
      if (ir_write)  n_ir_write++;
      if (state == 3'd2) last_exec_alu = alu_op;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1;
    check_lit("rst_state", 64'(state), 64'd0);
    check_lit("rst_retired", 64'(retired), 64'd0);
    check_lit("rst_bus_error", 64'(bus_error), 64'd0);
    check_lit("rst_illegal", 64'(illegal), 64'd0);
    model_reset();

    gen_instr(6'd0, 4'd2, 0, 0, 1'b0);
    run_stream();
    check_lit("rtype_alu_op", 64'(last_exec_alu), 64'b0001);
    check_lit("rtype_reg_write_cycles", 64'(n_reg_write), 64'd1);
    check_lit("rtype_latency", 64'(n_cycles), 64'd4);
    check_lit("rtype_retired", 64'(retired), 64'd1);

    gen_instr(6'd10, 4'd0, 0, 3, 1'b0);
    run_stream();
    check_lit("load_mem_read_cycles", 64'(n_mem_read), 64'd4);
    check_lit("load_latency", 64'(n_cycles), 64'd8);
    check_lit("load_retired", 64'(retired), 64'd2);

    gen_instr(6'd18, 4'd0, 0, 0, 1'b0);
    gen_instr(6'd19, 4'd0, 0, 0, 1'b0);
    run_stream();
    check_lit("pushpop_sp_write", 64'(n_sp_write), 64'd2);
    check_lit("pushpop_latency", 64'(n_cycles), 64'd10);
    check_lit("pushpop_retired", 64'(retired), 64'd4);

    gen_instr(6'd21, 4'd0, 0, 0, 1'b0);
    run_stream();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_lit("illegal_flag", 64'(illegal), 64'd1);
    check_lit("illegal_state", 64'(state), 64'd5);
    check_lit("illegal_retired", 64'(retired), 64'd4);
    add_reset();
    run_stream();
`else
    check_lit("illegal_flag", 64'(illegal), 64'd0);
    check_lit("illegal_state", 64'(state), 64'd0);
    check_lit("illegal_retired", 64'(retired), 64'd5);
`endif

    gen_instr(6'd0, 4'd0, WAIT_MAX + 1, 0, 1'b0);
    run_stream();
    check_lit("timeout_ir_write", 64'(n_ir_write), 64'd0);
    check_lit("timeout_cycles", 64'(n_cycles), 64'd19);
    check_lit("timeout_bus_error", 64'(bus_error), 64'd1);
    check_lit("timeout_state", 64'(state), 64'd5);
    add_reset();
    run_stream();
    check_lit("timeout_rst_bus_error", 64'(bus_error), 64'd0);
    check_lit("timeout_rst_state", 64'(state), 64'd0);

    gen_instr(6'd0, 4'd3, WAIT_MAX, 0, 1'b0);
    run_stream();
    check_lit("edge_wait_bus_error", 64'(bus_error), 64'd0);
    check_lit("edge_wait_latency", 64'(n_cycles), 64'd19);
    check_lit("edge_wait_retired", 64'(retired), 64'd1);

    gen_instr(6'd11, 4'd0, 0, 0, 1'b1);
    run_stream();
    check_lit("mem_rst_state", 64'(state), 64'd0);
    check_lit("mem_rst_mem_write", 64'(mem_write), 64'd0);
    check_lit("mem_rst_retired", 64'(retired), 64'd0);

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [OPCODE_W-1:0] op;
      r = $urandom_range(0, 45);
      if (r < 32) op = OPCODE_W'(r);
      else if (r < 44) op = OPCODE_W'((r % 2 == 0) ? $urandom_range(10, 13) : $urandom_range(18, 19));
      else op = OPCODE_W'(32 + $urandom_range(0, 31));
      gen_instr(op, rnd_fn(), pick_wait(), pick_wait(), ($urandom_range(0, 29) == 0));
      if (m_halted) add_reset();
    end
    run_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
